// File: rtl/axum_ctx_copy_engine.sv
// Copies a contiguous range of registers between two inactive contexts of the
// mapped register-file window, one read beat followed by one write beat per register.
module axum_ctx_copy_engine #(
  parameter int unsigned AddressWidth = 32,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned NrCtx        = 4,
  parameter logic [AddressWidth-1:0] BaseAddr = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [$clog2(NrCtx)-1:0] src_ctx_i,
  input  logic [$clog2(NrCtx)-1:0] dst_ctx_i,
  input  logic [4:0]              first_reg_i,
  input  logic [4:0]              last_reg_i,
  input  logic                    abort_i,
  input  logic [$clog2(NrCtx)-1:0] ctx_sel_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    map_req_o,
  output logic [AddressWidth-1:0] map_addr_o,
  output logic                    map_we_o,
  output logic [DataWidth/8-1:0]  map_be_o,
  output logic [DataWidth-1:0]    map_wdata_o,
  input  logic                    map_rvalid_i,
  input  logic [DataWidth-1:0]    map_rdata_i,
  input  logic                    map_err_i
);

  localparam int unsigned CtxW = $clog2(NrCtx);

  typedef enum logic [2:0] {IDLE, RD, RD_W, WR, WR_W, DONE} state_t;

  state_t               state;
  logic [CtxW-1:0]      src_q;
  logic [CtxW-1:0]      dst_q;
  logic [4:0]           idx_q;
  logic [4:0]           last_q;
  logic [DataWidth-1:0] data_q;
  logic                 stop_pend;

  logic cmd_bad;
  logic conflict;

  function automatic logic [AddressWidth-1:0] beat_addr(input logic [CtxW-1:0] ctx,
                                                        input logic [4:0] r);
    beat_addr = BaseAddr | (AddressWidth'(ctx) << 7) | (AddressWidth'(r) << 2);
  endfunction

  assign cmd_bad = (src_ctx_i == dst_ctx_i) || (src_ctx_i == ctx_sel_i) ||
                   (dst_ctx_i == ctx_sel_i) || (first_reg_i > last_reg_i);

  // A context becoming active under us would make the core race our writes.
  assign conflict = busy_o && ((ctx_sel_i == src_q) || (ctx_sel_i == dst_q));

  assign map_wdata_o = data_q;
  assign map_be_o    = {(DataWidth/8){map_req_o}};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      idx_q      <= '0;
      last_q     <= '0;
      data_q     <= '0;
      stop_pend  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      map_req_o  <= 1'b0;
      map_we_o   <= 1'b0;
      map_addr_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            src_q     <= src_ctx_i;
            dst_q     <= dst_ctx_i;
            last_q    <= last_reg_i;
            idx_q     <= first_reg_i;
            stop_pend <= 1'b0;
            err_o     <= cmd_bad;
            if (cmd_bad) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state      <= RD;
              busy_o     <= 1'b1;
              map_req_o  <= 1'b1;
              map_we_o   <= 1'b0;
              map_addr_o <= beat_addr(src_ctx_i, first_reg_i);
            end
          end
        end
        RD: begin
          map_req_o <= 1'b0;
          state     <= RD_W;
          if (abort_i || conflict) stop_pend <= 1'b1;
        end
        RD_W: begin
          if (map_rvalid_i) data_q <= map_rdata_i;
          if (!map_rvalid_i || map_err_i || stop_pend || conflict) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            err_o  <= 1'b1;
          end else begin
            state      <= WR;
            map_req_o  <= 1'b1;
            map_we_o   <= 1'b1;
            map_addr_o <= beat_addr(dst_q, idx_q);
          end
        end
        WR: begin
          map_req_o <= 1'b0;
          map_we_o  <= 1'b0;
          state     <= WR_W;
          if (abort_i || conflict) stop_pend <= 1'b1;
        end
        WR_W: begin
          if (!map_rvalid_i || map_err_i || stop_pend || conflict) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            err_o  <= 1'b1;
          end else if (idx_q == last_q) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            err_o  <= 1'b0;
          end else begin
            // idx_q < last_q <= 31 here, so the increment cannot wrap.
            idx_q      <= idx_q + 5'd1;
            state      <= RD;
            map_req_o  <= 1'b1;
            map_we_o   <= 1'b0;
            map_addr_o <= beat_addr(src_q, idx_q + 5'd1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          busy_o    <= 1'b0;
          map_req_o <= 1'b0;
          map_we_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axum_ctx_copy_engine.sv
// Bench for axum_ctx_copy_engine: bus memory responder, table vectors, random commands
// against a per-register reference model, plus reset and context-conflict sequences.
module tb_axum_ctx_copy_engine;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  src_ctx_i = '0;
  logic [1:0]  dst_ctx_i = '0;
  logic [4:0]  first_reg_i = '0;
  logic [4:0]  last_reg_i = '0;
  logic        abort_i = 1'b0;
  logic [1:0]  ctx_sel_i = '0;
  logic        busy_o, done_o, err_o;
  logic        map_req_o, map_we_o;
  logic [31:0] map_addr_o;
  logic [3:0]  map_be_o;
  logic [31:0] map_wdata_o;
  logic        map_rvalid_i = 1'b0;
  logic [31:0] map_rdata_i = '0;
  logic        map_err_i = 1'b0;

  axum_ctx_copy_engine dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .src_ctx_i(src_ctx_i), .dst_ctx_i(dst_ctx_i),
    .first_reg_i(first_reg_i), .last_reg_i(last_reg_i),
    .abort_i(abort_i), .ctx_sel_i(ctx_sel_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .map_req_o(map_req_o), .map_addr_o(map_addr_o), .map_we_o(map_we_o),
    .map_be_o(map_be_o), .map_wdata_o(map_wdata_o),
    .map_rvalid_i(map_rvalid_i), .map_rdata_i(map_rdata_i), .map_err_i(map_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic [1:0] src;
    logic [1:0] dst;
    logic [1:0] sel;
    logic [4:0] first;
    logic [4:0] last;
    int         err_at;
    int         drop_at;
    int         abort_reg;
    bit         exp_err;
    int         exp_busy;
  } vec_t;

  logic [31:0] mem  [0:127];
  logic [31:0] mmem [0:127];
  beat_t       log_q[$];
  beat_t       exp_q[$];
  int          rd_cnt = 0;
  int          err_at = 0;
  int          drop_at = 0;
  int          abort_reg = -1;
  bit          pend_req = 0;
  bit          pend_we = 0;
  logic [31:0] pend_addr = '0;
  int          n_vec = 0;
  int          n_bad = 0;

  // Bus slave: responds one cycle after each request, records every beat.
  always @(posedge clk_i) begin
    #1;
    map_rvalid_i = 1'b0;
    map_err_i    = 1'b0;
    map_rdata_i  = '0;
    abort_i      = 1'b0;
    if (pend_req) begin
      if (!pend_we) begin
        rd_cnt++;
        if (rd_cnt != drop_at) begin
          map_rvalid_i = 1'b1;
          map_rdata_i  = mem[pend_addr[8:2]];
          map_err_i    = (rd_cnt == err_at);
        end
      end else begin
        map_rvalid_i = 1'b1;
      end
    end
    if (map_req_o) begin
      log_q.push_back('{map_we_o, map_addr_o, map_we_o ? map_wdata_o : 32'h0});
      if (map_we_o) mem[map_addr_o[8:2]] = map_wdata_o;
      if (map_we_o && abort_reg >= 0 && int'(map_addr_o[6:2]) == abort_reg) abort_i = 1'b1;
    end
    pend_req  = map_req_o;
    pend_we   = map_we_o;
    pend_addr = map_addr_o;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the register range, stop on the first error/drop/abort.
  task automatic model_run(input vec_t v, output bit e, output int busy);
    int reads;
    logic [31:0] d;
    exp_q.delete();
    e = 0;
    busy = 0;
    reads = 0;
    if (v.src == v.dst || v.src == v.sel || v.dst == v.sel || v.first > v.last) begin
      e = 1;
      return;
    end
    for (int r = int'(v.first); r <= int'(v.last); r++) begin
      reads++;
      exp_q.push_back('{1'b0, 32'(int'(v.src) * 128 + r * 4), 32'h0});
      busy += 2;
      if (reads == v.err_at || reads == v.drop_at) begin
        e = 1;
        return;
      end
      d = mmem[int'(v.src) * 32 + r];
      exp_q.push_back('{1'b1, 32'(int'(v.dst) * 128 + r * 4), d});
      mmem[int'(v.dst) * 32 + r] = d;
      busy += 2;
      if (r == v.abort_reg) begin
        e = 1;
        return;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input bit use_tbl, input string tag);
    bit m_err;
    int m_busy, cyc, busy_n, bad_beats, bad_mem;
    bit ex_err;
    int ex_busy;
    model_run(v, m_err, m_busy);
    ex_err  = use_tbl ? v.exp_err : m_err;
    ex_busy = use_tbl ? v.exp_busy : m_busy;
    log_q.delete();
    rd_cnt    = 0;
    err_at    = v.err_at;
    drop_at   = v.drop_at;
    abort_reg = v.abort_reg;
    src_ctx_i = v.src; dst_ctx_i = v.dst; ctx_sel_i = v.sel;
    first_reg_i = v.first; last_reg_i = v.last;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    cyc = 0; busy_n = 0;
    while (!done_o && cyc < 1000) begin
      if (busy_o) busy_n++;
      @(posedge clk_i); #1;
      cyc++;
    end
    check({tag, ".done"}, done_o, 1);
    check({tag, ".err"}, err_o, ex_err);
    check({tag, ".busy_cycles"}, busy_n, ex_busy);
    check({tag, ".latency"}, cyc, ex_busy);
    check({tag, ".beat_count"}, log_q.size(), exp_q.size());
    bad_beats = 0;
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      if (log_q[i].we !== exp_q[i].we || log_q[i].addr !== exp_q[i].addr ||
          log_q[i].data !== exp_q[i].data) bad_beats++;
    check({tag, ".beats"}, bad_beats, 0);
    bad_mem = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== mmem[i]) bad_mem++;
    check({tag, ".regfile"}, bad_mem, 0);
    @(posedge clk_i); #1;
    check({tag, ".done_pulse"}, done_o, 0);
    check({tag, ".err_hold"}, err_o, ex_err);
    err_at = 0; drop_at = 0; abort_reg = -1;
  endtask

  vec_t tbl[11];

  initial begin
    vec_t v;
    int cyc, nwr;
    tbl[0]  = '{2'd1, 2'd2, 2'd0, 5'd1,  5'd31, 0, 0, -1, 1'b0, 124};
    tbl[1]  = '{2'd3, 2'd3, 2'd0, 5'd0,  5'd5,  0, 0, -1, 1'b1, 0};
    tbl[2]  = '{2'd1, 2'd2, 2'd1, 5'd0,  5'd5,  0, 0, -1, 1'b1, 0};
    tbl[3]  = '{2'd2, 2'd1, 2'd0, 5'd5,  5'd5,  0, 0, -1, 1'b0, 4};
    tbl[4]  = '{2'd1, 2'd2, 2'd0, 5'd0,  5'd10, 3, 0, -1, 1'b1, 10};
    tbl[5]  = '{2'd1, 2'd3, 2'd0, 5'd5,  5'd10, 0, 0, 7,  1'b1, 12};
    tbl[6]  = '{2'd1, 2'd2, 2'd0, 5'd6,  5'd4,  0, 0, -1, 1'b1, 0};
    tbl[7]  = '{2'd0, 2'd3, 2'd1, 5'd30, 5'd31, 0, 0, -1, 1'b0, 8};
    tbl[8]  = '{2'd2, 2'd3, 2'd1, 5'd0,  5'd0,  0, 0, -1, 1'b0, 4};
    tbl[9]  = '{2'd1, 2'd2, 2'd2, 5'd0,  5'd3,  0, 0, -1, 1'b1, 0};
    tbl[10] = '{2'd2, 2'd0, 2'd1, 5'd3,  5'd8,  0, 2, -1, 1'b1, 6};

    for (int i = 0; i < 128; i++) begin
      mem[i]  = $urandom;
      mmem[i] = mem[i];
    end

    repeat (3) @(posedge clk_i);
    #1;
    check("reset_outputs", {busy_o, done_o, err_o, map_req_o, map_we_o, map_be_o,
                            map_addr_o, map_wdata_o}, 64'h0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    for (int i = 0; i < 11; i++) run_vec(tbl[i], 1'b1, $sformatf("tbl%0d", i));

    for (int i = 0; i < 40; i++) begin
      v.src = 2'($urandom); v.dst = 2'($urandom); v.sel = 2'($urandom);
      v.first = 5'($urandom_range(0, 31));
      v.last  = 5'((int'(v.first) + $urandom_range(0, 6) > 31) ? 31 :
                   int'(v.first) + $urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) v.last = 5'($urandom_range(0, 31));
      v.err_at    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      v.drop_at   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
      v.abort_reg = ($urandom_range(0, 4) == 0) ? $urandom_range(int'(v.first), 31) : -1;
      v.exp_err = 1'b0; v.exp_busy = 0;
      run_vec(v, 1'b0, $sformatf("rnd%0d", i));
    end

    // Reset while a read response is outstanding.
    src_ctx_i = 2'd1; dst_ctx_i = 2'd3; ctx_sel_i = 2'd0;
    first_reg_i = 5'd4; last_reg_i = 5'd9;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("rst.req_in_rd", map_req_o, 1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("rst.outputs", {busy_o, done_o, err_o, map_req_o, map_we_o, map_be_o,
                          map_addr_o, map_wdata_o}, 64'h0);
    cyc = 0;
    repeat (6) begin
      @(posedge clk_i); #1;
      if (done_o || busy_o || map_req_o) cyc++;
    end
    check("rst.quiet", cyc, 0);
    run_vec('{2'd1, 2'd3, 2'd0, 5'd4, 5'd9, 0, 0, -1, 1'b0, 24}, 1'b1, "rst.rerun");

    // Destination context becomes active mid-copy.
    log_q.delete(); rd_cnt = 0;
    src_ctx_i = 2'd1; dst_ctx_i = 2'd2; ctx_sel_i = 2'd0;
    first_reg_i = 5'd0; last_reg_i = 5'd31;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1;
    ctx_sel_i = 2'd2;
    cyc = 0;
    while (!done_o && cyc < 100) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check("conflict.done", done_o, 1);
    check("conflict.err", err_o, 1);
    nwr = 0;
    foreach (log_q[i]) if (log_q[i].we) nwr++;
    check("conflict.partial", nwr < 32, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
